// File: rtl/global_resource_arbiter_if.sv
// global_resource_arbiter_if: unit request/grant and shared-memory handshake bundle
interface global_resource_arbiter_if #(
  parameter int NUM_UNITS = 4
);
  localparam int IDW = $clog2(NUM_UNITS);
  logic [NUM_UNITS-1:0] req_i;
  logic [NUM_UNITS-1:0] grant_o;
  logic [IDW-1:0]       owner_id_o;
  logic                 busy_o;
  logic [NUM_UNITS-1:0] unit_mem_req_i;
  logic                 mem_req_o;
  logic                 mem_grant_i;
  logic                 mem_done_i;
  logic [NUM_UNITS-1:0] unit_grant_o;
  logic [NUM_UNITS-1:0] unit_done_o;
  logic                 timeout_o;
  modport master (
    output req_i, unit_mem_req_i, mem_grant_i, mem_done_i,
    input  grant_o, owner_id_o, busy_o, mem_req_o, unit_grant_o, unit_done_o, timeout_o
  );
  modport slave (
    input  req_i, unit_mem_req_i, mem_grant_i, mem_done_i,
    output grant_o, owner_id_o, busy_o, mem_req_o, unit_grant_o, unit_done_o, timeout_o
  );
endinterface

// File: rtl/global_resource_arbiter.sv
// global_resource_arbiter: round-robin owner of the shared memory port with hold-time revoke
module global_resource_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int MAX_HOLD  = 64
) (
  input logic                      clk,
  input logic                      rst,
  global_resource_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_UNITS);
  localparam int HW  = $clog2(MAX_HOLD + 1);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t               state_q, state_d;
  logic [IDW-1:0]       owner_q, owner_d, rr_q, rr_d, winner;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 timeout_q, timeout_d;
  logic                 busy;
  logic [NUM_UNITS-1:0] grant;
  // Descending scan so the nearest requester at or after rr_q is the last assignment
  always_comb begin
    winner = rr_q;
    for (int i = NUM_UNITS - 1; i >= 0; i--)
      if (bus.req_i[IDW'((int'(rr_q) + i) % NUM_UNITS)]) winner = IDW'((int'(rr_q) + i) % NUM_UNITS);
  end
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    timeout_d = 1'b0;
    hold_d    = (state_q != GRANT) ? '0 : (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
    unique case (state_q)
      IDLE: if (|bus.req_i) begin
        state_d = GRANT;
        owner_d = winner;
      end
      GRANT: if (!bus.req_i[owner_q] || hold_q == HW'(MAX_HOLD - 1)) begin
        state_d   = RELEASE;
        timeout_d = bus.req_i[owner_q];
      end
      RELEASE: begin
        state_d = IDLE;
        rr_d    = (owner_q == IDW'(NUM_UNITS - 1)) ? '0 : owner_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_q      <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end
  assign busy             = (state_q == GRANT);
  assign grant            = busy ? NUM_UNITS'(1) << owner_q : '0;
  assign bus.grant_o      = grant;
  assign bus.busy_o       = busy;
  assign bus.owner_id_o   = owner_q;
  assign bus.timeout_o    = timeout_q;
  assign bus.mem_req_o    = bus.unit_mem_req_i[owner_q] & busy;
  assign bus.unit_grant_o = grant & {NUM_UNITS{bus.mem_grant_i}};
  assign bus.unit_done_o  = grant & {NUM_UNITS{bus.mem_done_i}};
endmodule

// File: tb/tb_global_resource_arbiter.sv
// tb_global_resource_arbiter: directed scenarios plus random traffic against a transaction-level model
module tb_global_resource_arbiter;
  localparam int N  = 4;
  localparam int MH = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int errors  = 0;
  always #5 clk = ~clk;
  global_resource_arbiter_if #(.NUM_UNITS(N)) bus();
  global_resource_arbiter #(.NUM_UNITS(N), .MAX_HOLD(MH)) dut (.clk(clk), .rst(rst), .bus(bus));
  // Model: who owns the port, for how many cycles, and how many edges remain before arbitration resumes
  int m_owner, m_held, m_wait, m_ptr;
  bit m_to;
  function automatic void model_reset();
    m_owner = -1;
    m_held  = 0;
    m_wait  = 0;
    m_ptr   = 0;
    m_to    = 0;
  endfunction
  function automatic void model_edge(logic [N-1:0] req);
    m_to = 0;
    if (m_owner >= 0) begin
      m_held++;
      if (!req[m_owner] || m_held == MH) begin
        m_to    = req[m_owner];
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_wait  = 1;
      end
    end else if (m_wait > 0) m_wait--;
    else if (req != '0) begin
      for (int k = 0; k < N; k++)
        if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      m_held = 0;
    end
  endfunction
  task automatic tick(input logic [N-1:0] req, input logic [N-1:0] umr, input logic mg, input logic md);
    bus.req_i          = req;
    bus.unit_mem_req_i = umr;
    bus.mem_grant_i    = mg;
    bus.mem_done_i     = md;
    @(posedge clk);
    model_edge(req);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.req_i = '0; bus.unit_mem_req_i = '0; bus.mem_grant_i = 1'b0; bus.mem_done_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask
  task automatic test_reset();
    bus.req_i = '1; bus.unit_mem_req_i = '1; bus.mem_grant_i = 1'b1; bus.mem_done_i = 1'b1;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({bus.grant_o, bus.busy_o, bus.owner_id_o, bus.timeout_o, bus.unit_grant_o, bus.unit_done_o, bus.mem_req_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs grant=%b busy=%b owner=%0d to=%b ug=%b ud=%b mreq=%b, required all 0",
               bus.grant_o, bus.busy_o, bus.owner_id_o, bus.timeout_o, bus.unit_grant_o, bus.unit_done_o, bus.mem_req_o);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({bus.grant_o, bus.busy_o} !== '0) begin
      errors++;
      $display("FAIL reset_held grant=%b busy=%b, required 0000 0", bus.grant_o, bus.busy_o);
    end
    do_reset();
  endtask
  task automatic test_single();
    do_reset();
    tick(4'b0100, '0, 0, 0);
    vectors++;
    if ({bus.grant_o, bus.owner_id_o, bus.busy_o} !== {4'b0100, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL single_grant grant=%b owner=%0d busy=%b, required 0100 2 1", bus.grant_o, bus.owner_id_o, bus.busy_o);
    end
    tick('0, '0, 0, 0);
    vectors++;
    if ({bus.grant_o, bus.busy_o, bus.timeout_o} !== 6'b0) begin
      errors++;
      $display("FAIL single_release grant=%b busy=%b to=%b, required 0000 0 0", bus.grant_o, bus.busy_o, bus.timeout_o);
    end
    tick('0, '0, 0, 0);
    tick(4'b0100, '0, 0, 0);
    vectors++;
    if (bus.grant_o !== 4'b0100) begin
      errors++;
      $display("FAIL single_regrant grant=%b, required 0100", bus.grant_o);
    end
  endtask
  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] oh;
    do_reset();
    foreach (order[g]) begin
      oh = N'(1) << order[g];
      tick(4'b1111, '0, 0, 0);
      for (int c = 0; c < 3; c++) begin
        vectors++;
        if (bus.grant_o !== oh) begin
          errors++;
          $display("FAIL rr_grant#%0d cycle%0d grant=%b, required %b", g, c, bus.grant_o, oh);
        end
        if (c < 2) tick(4'b1111, '0, 0, 0);
      end
      tick(4'b1111 & ~oh, '0, 0, 0);
      vectors++;
      if ({bus.grant_o, bus.busy_o} !== 5'b0) begin
        errors++;
        $display("FAIL rr_gap#%0d grant=%b busy=%b, required 0000 0", g, bus.grant_o, bus.busy_o);
      end
      tick(4'b1111 & ~oh, '0, 0, 0);
    end
  endtask
  task automatic test_timeout();
    do_reset();
    tick(4'b0110, '0, 0, 0);
    for (int c = 1; c < MH; c++) begin
      tick(4'b0110, '0, 0, 0);
      vectors++;
      if ({bus.grant_o, bus.timeout_o} !== {4'b0010, 1'b0}) begin
        errors++;
        $display("FAIL timeout_hold cycle%0d grant=%b to=%b, required 0010 0", c + 1, bus.grant_o, bus.timeout_o);
      end
    end
    tick(4'b0110, '0, 0, 0);
    vectors++;
    if ({bus.grant_o, bus.timeout_o} !== {4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL timeout_revoke grant=%b to=%b, required 0000 1", bus.grant_o, bus.timeout_o);
    end
    tick(4'b0110, '0, 0, 0);
    vectors++;
    if (bus.timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse_width to=%b, required 0", bus.timeout_o);
    end
    tick(4'b0110, '0, 0, 0);
    vectors++;
    if (bus.grant_o !== 4'b0100) begin
      errors++;
      $display("FAIL timeout_next_winner grant=%b, required 0100", bus.grant_o);
    end
  endtask
  task automatic test_steering();
    do_reset();
    tick(4'b1000, 4'b0001, 0, 0);
    vectors++;
    if ({bus.owner_id_o, bus.mem_req_o} !== {2'd3, 1'b0}) begin
      errors++;
      $display("FAIL steer_nonowner_req owner=%0d mreq=%b, required 3 0", bus.owner_id_o, bus.mem_req_o);
    end
    bus.unit_mem_req_i = 4'b1000; bus.mem_grant_i = 1'b1; bus.mem_done_i = 1'b1;
    #1;
    vectors++;
    if ({bus.unit_grant_o, bus.unit_done_o, bus.mem_req_o} !== {4'b1000, 4'b1000, 1'b1}) begin
      errors++;
      $display("FAIL steer_owner ug=%b ud=%b mreq=%b, required 1000 1000 1", bus.unit_grant_o, bus.unit_done_o, bus.mem_req_o);
    end
    tick('0, '0, 0, 0);
    tick('0, '0, 0, 0);
    bus.unit_mem_req_i = '1; bus.mem_grant_i = 1'b1; bus.mem_done_i = 1'b1;
    #1;
    vectors++;
    if ({bus.unit_grant_o, bus.unit_done_o, bus.mem_req_o} !== 9'b0) begin
      errors++;
      $display("FAIL steer_idle ug=%b ud=%b mreq=%b, required 0000 0000 0", bus.unit_grant_o, bus.unit_done_o, bus.mem_req_o);
    end
  endtask
  task automatic test_limit_race();
    do_reset();
    tick(4'b0001, '0, 0, 0);
    for (int c = 1; c < MH; c++) tick(4'b0001, '0, 0, 0);
    vectors++;
    if (bus.grant_o !== 4'b0001) begin
      errors++;
      $display("FAIL race_last_cycle grant=%b, required 0001", bus.grant_o);
    end
    tick('0, '0, 0, 0);
    vectors++;
    if ({bus.grant_o, bus.timeout_o} !== 5'b0) begin
      errors++;
      $display("FAIL race_release grant=%b to=%b, required 0000 0", bus.grant_o, bus.timeout_o);
    end
  endtask
  task automatic test_async_reset();
    do_reset();
    tick(4'b0100, '0, 0, 0);
    tick(4'b0100, '0, 0, 0);
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.grant_o, bus.busy_o, bus.timeout_o} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset grant=%b busy=%b to=%b, required 0000 0 0", bus.grant_o, bus.busy_o, bus.timeout_o);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick(4'b0110, '0, 0, 0);
    vectors++;
    if ({bus.grant_o, bus.owner_id_o} !== {4'b0010, 2'd1}) begin
      errors++;
      $display("FAIL async_reset_rr grant=%b owner=%0d, required 0010 1", bus.grant_o, bus.owner_id_o);
    end
  endtask
  task automatic test_random();
    logic [N-1:0] r = '0, umr, eg;
    logic mg, md;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) r = N'($urandom);
      umr = N'($urandom);
      mg  = 1'($urandom_range(0, 1));
      md  = 1'($urandom_range(0, 1));
      tick(r, umr, mg, md);
      eg = (m_owner >= 0) ? N'(1) << m_owner : '0;
      vectors++;
      if ({bus.grant_o, bus.busy_o, bus.timeout_o} !== {eg, m_owner >= 0, m_to}) begin
        errors++;
        $display("FAIL rand_state c%0d grant=%b busy=%b to=%b, required %b %b %b",
                 c, bus.grant_o, bus.busy_o, bus.timeout_o, eg, m_owner >= 0, m_to);
      end
      vectors++;
      if ({bus.unit_grant_o, bus.unit_done_o, bus.mem_req_o} !== {eg & {N{mg}}, eg & {N{md}}, |(eg & umr)}) begin
        errors++;
        $display("FAIL rand_steer c%0d ug=%b ud=%b mreq=%b, required %b %b %b",
                 c, bus.unit_grant_o, bus.unit_done_o, bus.mem_req_o, eg & {N{mg}}, eg & {N{md}}, |(eg & umr));
      end
      if (m_owner >= 0) begin
        vectors++;
        if (bus.owner_id_o !== 2'(m_owner)) begin
          errors++;
          $display("FAIL rand_owner c%0d owner=%0d, required %0d", c, bus.owner_id_o, m_owner);
        end
      end
    end
  endtask
  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_steering();
    test_limit_race();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
